tmr_voter_pipe: RTL and testbench

TMR_VOTER_PIPE -- requirements
Module: tmr_voter_pipe

---
 rtl/tmr_voter_pipe.sv | 147 ++++++++++++++
 tb/tb_tmr_voter_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tmr_voter_pipe.sv
// Two-stage triple-modular-redundancy voter with per-channel mismatch tracking.
// Optional macro TMR_VOTER_ERRCNT_EN builds saturating error counters with a fault threshold.
module tmr_voter_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned THRESH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       mismatch,
    output logic             no_majority,
    output logic [2:0]       fault,
    output logic [CNT_W-1:0] err_cnt_a,
    output logic [CNT_W-1:0] err_cnt_b,
    output logic [CNT_W-1:0] err_cnt_c
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] s1_c;

    logic [WIDTH-1:0] vote_c;
    logic [2:0]       mm_c;
    logic             nm_c;
    logic [2:0]       fault_d;

    // Stage 1: capture the three redundant copies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_a     <= a;
            s1_b     <= b;
            s1_c     <= c;
        end
    end

    // Bitwise 2-of-3 vote and per-channel disagreement
    always_comb begin
        vote_c  = (s1_a & s1_b) | (s1_a & s1_c) | (s1_b & s1_c);
        mm_c    = {s1_c != vote_c, s1_b != vote_c, s1_a != vote_c};
        nm_c    = (s1_a != s1_b) && (s1_a != s1_c) && (s1_b != s1_c);
    end

    // Stage 2: data outputs hold while no valid word arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out         <= '0;
            mismatch    <= '0;
            no_majority <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out         <= vote_c;
                mismatch    <= mm_c;
                no_majority <= nm_c;
            end
        end
    end

`ifdef TMR_VOTER_ERRCNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    // Saturating counters; clr takes priority over any increment
    always_comb begin
        fault_d = fault;
        for (int k = 0; k < 3; k++) begin
            cnt_d[k] = cnt_q[k];
        end
        if (clr) begin
            fault_d = '0;
            for (int k = 0; k < 3; k++) begin
                cnt_d[k] = '0;
            end
        end else if (s1_valid) begin
            for (int k = 0; k < 3; k++) begin
                if (mm_c[k] && (cnt_q[k] != CNT_MAX)) begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
                if (cnt_d[k] >= CNT_W'(THRESH)) begin
                    fault_d[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault <= '0;
            for (int k = 0; k < 3; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            fault <= fault_d;
            for (int k = 0; k < 3; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign err_cnt_a = cnt_q[0];
    assign err_cnt_b = cnt_q[1];
    assign err_cnt_c = cnt_q[2];
`else
    // Without counters a single disagreement marks the channel faulty
    logic unused_thresh;
    assign unused_thresh = ^THRESH;

    always_comb begin
        fault_d = fault;
        if (clr) begin
            fault_d = '0;
        end else if (s1_valid) begin
            fault_d = fault | mm_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault <= '0;
        end else begin
            fault <= fault_d;
        end
    end

    assign err_cnt_a = '0;
    assign err_cnt_b = '0;
    assign err_cnt_c = '0;
`endif

endmodule

// File: tb/tb_tmr_voter_pipe.sv
// Randomized self-checking bench for tmr_voter_pipe against a queue-based reference model.
module tb_tmr_voter_pipe;

    localparam int unsigned W    = 8;
    localparam int unsigned CW   = 3;
    localparam int unsigned TH   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  a, b, c;
    logic          clr;
    logic          out_valid;
    logic [W-1:0]  out;
    logic [2:0]    mismatch;
    logic          no_majority;
    logic [2:0]    fault;
    logic [CW-1:0] err_cnt_a, err_cnt_b, err_cnt_c;

    tmr_voter_pipe #(.WIDTH(W), .CNT_W(CW), .THRESH(TH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c), .clr(clr),
        .out_valid(out_valid), .out(out), .mismatch(mismatch), .no_majority(no_majority),
        .fault(fault), .err_cnt_a(err_cnt_a), .err_cnt_b(err_cnt_b), .err_cnt_c(err_cnt_c)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         v;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
    } word_t;

    word_t      q[$];
    bit         m_valid;
    logic [7:0] m_out;
    logic [2:0] m_mm;
    bit         m_nm;
    int         m_cnt[3];
    logic [2:0] m_fault;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] majority(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            int ones;
            ones = int'(x[i]) + int'(y[i]) + int'(z[i]);
            r[i] = (ones >= 2);
        end
        return r;
    endfunction

    task automatic model_reset();
        word_t idle;
        idle = '{v: 1'b0, a: 8'h0, b: 8'h0, c: 8'h0};
        q = {};
        q.push_back(idle);
        m_valid = 0; m_out = '0; m_mm = '0; m_nm = 0; m_fault = '0;
        for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    endtask

    // One clock edge of the reference: the word accepted last edge reaches the output
    task automatic model_edge();
        word_t      w;
        word_t      cur;
        logic [7:0] ch[3];
        logic [7:0] v;
        w   = q.pop_front();
        cur = '{v: in_valid, a: a, b: b, c: c};
        q.push_back(cur);
        m_valid = w.v;
        ch[0] = w.a; ch[1] = w.b; ch[2] = w.c;
        v = majority(w.a, w.b, w.c);
        if (w.v) begin
            m_out = v;
            for (int k = 0; k < 3; k++) m_mm[k] = (ch[k] != v);
            m_nm = (w.a != w.b) && (w.a != w.c) && (w.b != w.c);
        end
        if (clr) begin
            m_fault = '0;
            for (int k = 0; k < 3; k++) m_cnt[k] = 0;
        end else if (w.v) begin
            for (int k = 0; k < 3; k++) begin
                if (ch[k] != v) begin
`ifdef TMR_VOTER_ERRCNT_EN
                    if (m_cnt[k] < CMAX) m_cnt[k]++;
                    if (m_cnt[k] >= TH) m_fault[k] = 1'b1;
`else
                    m_fault[k] = 1'b1;
`endif
                end
            end
        end
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out", 32'(out), 32'(m_out));
        chk("mismatch", 32'(mismatch), 32'(m_mm));
        chk("no_majority", 32'(no_majority), 32'(m_nm));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("err_cnt_a", 32'(err_cnt_a), 32'(m_cnt[0]));
        chk("err_cnt_b", 32'(err_cnt_b), 32'(m_cnt[1]));
        chk("err_cnt_c", 32'(err_cnt_c), 32'(m_cnt[2]));
    endtask

    task automatic step(input bit v, input logic [7:0] aa, input logic [7:0] bb,
                        input logic [7:0] cc, input bit cl);
        in_valid = v; a = aa; b = bb; c = cc; clr = cl;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c = '0; clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Clean word, two-cycle latency then a single valid output
        step(1'b1, 8'hA5, 8'hA5, 8'hA5, 1'b0);
        chk("lat_early", 32'(out_valid), 32'h0);
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("clean_out", 32'(out), 32'hA5);
        chk("clean_mm", 32'(mismatch), 32'h0);
        idle(1);
        chk("clean_done", 32'(out_valid), 32'h0);

        // Three-way disagreement
        step(1'b1, 8'hFF, 8'h0F, 8'hF0, 1'b0);
        idle(1);
        chk("nomaj_out", 32'(out), 32'hFF);
        chk("nomaj_mm", 32'(mismatch), 32'h6);
        chk("nomaj_flag", 32'(no_majority), 32'h1);
`ifdef TMR_VOTER_ERRCNT_EN
        chk("nomaj_cnt_b", 32'(err_cnt_b), 32'h1);
        chk("nomaj_cnt_c", 32'(err_cnt_c), 32'h1);
`else
        chk("nomaj_cnt_b", 32'(err_cnt_b), 32'h0);
        chk("nomaj_fault", 32'(fault), 32'h6);
`endif
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        chk("clr_fault", 32'(fault), 32'h0);

        // Channel c corrupted four times, then one clean word
        for (int i = 0; i < 4; i++) step(1'b1, 8'h11, 8'h11, 8'h10, 1'b0);
        step(1'b1, 8'h11, 8'h11, 8'h11, 1'b0);
        chk("thresh_fault", 32'(fault), 32'h4);
`ifdef TMR_VOTER_ERRCNT_EN
        chk("thresh_cnt_c", 32'(err_cnt_c), 32'h4);
`endif
        idle(2);
        chk("thresh_sticky", 32'(fault), 32'h4);
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);

        // Saturation of channel a, then clr racing an increment
        for (int i = 0; i < 10; i++) step(1'b1, 8'h3C, 8'hC3, 8'hC3, 1'b0);
        idle(2);
`ifdef TMR_VOTER_ERRCNT_EN
        chk("sat_cnt_a", 32'(err_cnt_a), 32'(CMAX));
`endif
        chk("sat_fault", 32'(fault), 32'h1);
        step(1'b1, 8'h3C, 8'hC3, 8'hC3, 1'b1);
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        chk("clr_cnt_a", 32'(err_cnt_a), 32'h0);
        chk("clr_fault2", 32'(fault), 32'h0);

        // Reset mid-stream with two words in flight
        step(1'b1, 8'h01, 8'h01, 8'h02, 1'b0);
        step(1'b1, 8'h04, 8'h08, 8'h04, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        idle(3);
        chk("no_stale", 32'(out_valid), 32'h0);

        // Randomized traffic with occasional corruption and clears
        for (int i = 0; i < 400; i++) begin
            logic [7:0] base, ra, rb, rc;
            base = 8'($urandom);
            ra = base; rb = base; rc = base;
            if ($urandom_range(0, 3) == 0) ra = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rb = 8'($urandom);
            if ($urandom_range(0, 5) == 0) rc = 8'($urandom);
            step(1'($urandom_range(0, 3) != 0), ra, rb, rc, ($urandom_range(0, 40) == 0));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
